// File: rtl/calculator_pkg.sv
// Shared calculator definitions: button bit indices used as one-hot opcodes,
// command field widths, and the sequencer state encoding.
package calculator_pkg;

  // Button bit positions within a 5-bit one-hot op
  localparam int unsigned UP     = 0;  // multiply
  localparam int unsigned DOWN   = 1;  // clear
  localparam int unsigned LEFT   = 2;  // add
  localparam int unsigned RIGHT  = 3;  // subtract
  localparam int unsigned CENTER = 4;  // not a datapath op

  localparam int unsigned OP_W   = 5;
  localparam int unsigned OPND_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESPOND
  } seq_state_t;

  // Exactly one of UP/DOWN/LEFT/RIGHT set, and CENTER clear
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return !op[CENTER] && ($countones(op) == 1);
  endfunction

endpackage

// File: rtl/calc_rr_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req bit at or
// above ptr, wrapping to bit 0.
//   req    : request vector
//   ptr    : highest-priority index
//   gnt    : one-hot grant (zero when no request)
//   gnt_id : binary index of the grant
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [GW-1:0] gnt_id
);

  logic found;

  // Two passes: indices >= ptr first, then the wrapped range from 0
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (GW'(j) >= ptr)) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = GW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = GW'(j);
      end
    end
  end

endmodule

// File: rtl/calc_rr_sequencer.sv
// Shares one accumulator calculator datapath between NREQ requesters.
// Arbitrates round-robin, latches the winning command, pulses dp_start,
// waits for dp_done (bounded by TIMEOUT) and returns result with an ack.
//   req/req_op/req_operand : per-requester command inputs (held until ack)
//   ack/result/err         : completion pulse, captured accumulator, error pulse
//   busy/grant_id          : status
//   dp_start/dp_op/dp_operand, dp_done/dp_accum : datapath handshake
module calc_rr_sequencer import calculator_pkg::*; #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BITS    = 32,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*OP_W-1:0]   req_op,
  input  logic [NREQ*OPND_W-1:0] req_operand,
  output logic [NREQ-1:0]        ack,
  output logic [BITS-1:0]        result,
  output logic                   err,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   dp_start,
  output logic [OP_W-1:0]        dp_op,
  output logic [OPND_W-1:0]      dp_operand,
  input  logic                   dp_done,
  input  logic [BITS-1:0]        dp_accum
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     id_q, id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [GW-1:0]     arb_id;
  logic [OP_W-1:0]   sel_op;
  logic [OPND_W-1:0] sel_opnd;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Command fields of the arbitration winner
  always_comb begin
    sel_op   = '0;
    sel_opnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == arb_id) begin
        sel_op   = req_op[i*OP_W +: OP_W];
        sel_opnd = req_operand[i*OPND_W +: OPND_W];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  // Next state; registered outputs are computed for the state being entered
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    ack_d    = '0;
    err_d    = 1'b0;
    start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d   = arb_id;
          op_d   = sel_op;
          opnd_d = sel_opnd;
          if (op_is_legal(sel_op)) begin
            state_d = S_ISSUE;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_RESPOND;
            ack_d   = arb_gnt;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // done on the final count still counts as a normal completion
        if (dp_done) begin
          result_d = dp_accum;
          state_d  = S_RESPOND;
          ack_d    = NREQ'(1) << id_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESPOND;
          ack_d   = NREQ'(1) << id_q;
          err_d   = 1'b1;
        end
      end
      S_RESPOND: begin
        ptr_d   = (id_q == GW'(NREQ - 1)) ? '0 : id_q + GW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ack        = ack_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign grant_id   = id_q;
  assign dp_start   = start_q;
  assign dp_op      = op_q;
  assign dp_operand = opnd_q;

endmodule

// File: tb/tb_calc_rr_sequencer.sv
// Self-checking bench for calc_rr_sequencer (NREQ=2, TIMEOUT=16).
module tb_calc_rr_sequencer;
  import calculator_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned BITS    = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned GW      = 1;

  localparam logic [4:0] OP_MUL = 5'(1 << UP);
  localparam logic [4:0] OP_CLR = 5'(1 << DOWN);
  localparam logic [4:0] OP_ADD = 5'(1 << LEFT);
  localparam logic [4:0] OP_SUB = 5'(1 << RIGHT);
  localparam logic [4:0] OP_CTR = 5'(1 << CENTER);

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] req_op;
  logic [NREQ*16-1:0] req_operand;
  logic [NREQ-1:0]   ack;
  logic [BITS-1:0]   result;
  logic              err, busy;
  logic [GW-1:0]     grant_id;
  logic              dp_start;
  logic [4:0]        dp_op;
  logic [15:0]       dp_operand;
  logic              dp_done;
  logic [BITS-1:0]   dp_accum;

  calc_rr_sequencer #(.NREQ(NREQ), .BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_operand(req_operand),
    .ack(ack), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
    .dp_start(dp_start), .dp_op(dp_op), .dp_operand(dp_operand),
    .dp_done(dp_done), .dp_accum(dp_accum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level reference state
  int          ptr_m;
  logic [31:0] result_m;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ*5-1:0]  ops;
    logic [NREQ*16-1:0] opnds;
    int                 dly;     // cycles after dp_start to pulse done; 0 = never
    logic [31:0]        accum;
    bit                 stray;   // dp_done pulse while idle
    bit                 drop;    // release req right after the grant
    int                 exp_id;
    bit                 exp_start;
    bit                 exp_err;
    int                 exp_lat; // ack cycle, req sampled at cycle 0
    logic [31:0]        exp_result;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack"}, 64'(ack), 0);
    chk({tag, " err"}, 64'(err), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " dp_start"}, 64'(dp_start), 0);
    chk({tag, " result"}, 64'(result), 0);
    chk({tag, " grant_id"}, 64'(grant_id), 0);
    chk({tag, " dp_op"}, 64'(dp_op), 0);
    chk({tag, " dp_operand"}, 64'(dp_operand), 0);
  endtask

  function automatic vec_t mk(input logic [1:0] rq, input logic [4:0] op1, input logic [4:0] op0,
                              input logic [15:0] od1, input logic [15:0] od0, input int dly,
                              input logic [31:0] accum, input bit stray, input bit drop,
                              input int eid, input bit estart, input bit eerr, input int elat,
                              input logic [31:0] eres);
    vec_t v;
    v.req = rq; v.ops = {op1, op0}; v.opnds = {od1, od0};
    v.dly = dly; v.accum = accum; v.stray = stray; v.drop = drop;
    v.exp_id = eid; v.exp_start = estart; v.exp_err = eerr; v.exp_lat = elat;
    v.exp_result = eres;
    return v;
  endfunction

  // Reference model: winner by rotating scan, legality by bit count,
  // completion cycle from the done delay or the timeout.
  task automatic predict(inout vec_t v);
    int w;
    int ones;
    logic [4:0] op;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (ptr_m + i) % NREQ;
      if (w < 0 && v.req[idx]) w = idx;
    end
    op = v.ops[w*5 +: 5];
    ones = 0;
    for (int b = 0; b < 5; b++) ones += int'(op[b]);
    v.exp_id = w;
    v.exp_start = (ones == 1) && !op[CENTER];
    if (!v.exp_start) begin
      v.exp_lat = 1; v.exp_err = 1'b1; v.exp_result = result_m;
    end else if (v.dly >= 1 && v.dly <= int'(TIMEOUT) - 1) begin
      v.exp_lat = v.dly + 2; v.exp_err = 1'b0; v.exp_result = v.accum;
    end else begin
      v.exp_lat = int'(TIMEOUT) + 1; v.exp_err = 1'b1; v.exp_result = result_m;
    end
    result_m = v.exp_result;
    ptr_m = (w + 1) % NREQ;
  endtask

  // Entered and left in an IDLE cycle, just after the clock edge
  task automatic run_txn(input vec_t v, input string tag);
    logic [4:0]  eop;
    logic [15:0] eopd;
    eop  = v.ops[v.exp_id*5 +: 5];
    eopd = v.opnds[v.exp_id*16 +: 16];
    chk({tag, " idle busy"}, 64'(busy), 0);
    chk({tag, " idle ack"}, 64'(ack), 0);
    req = v.req; req_op = v.ops; req_operand = v.opnds;
    dp_done = v.stray; dp_accum = $urandom();
    tick();
    dp_done = 1'b0;
    if (v.drop) req = '0;
    chk({tag, " dp_start"}, 64'(dp_start), 64'(v.exp_start));
    chk({tag, " grant_id"}, 64'(grant_id), 64'(v.exp_id));
    if (v.exp_start) begin
      chk({tag, " dp_op"}, 64'(dp_op), 64'(eop));
      chk({tag, " dp_operand"}, 64'(dp_operand), 64'(eopd));
    end
    for (int c = 1; c <= v.exp_lat; c++) begin
      if (c > 1) chk({tag, " late dp_start"}, 64'(dp_start), 0);
      if (c < v.exp_lat) begin
        chk({tag, " early ack"}, 64'(ack), 0);
        chk({tag, " busy"}, 64'(busy), 1);
      end else begin
        chk({tag, " ack"}, 64'(ack), 64'(2'b01 << v.exp_id));
        chk({tag, " err"}, 64'(err), 64'(v.exp_err));
        chk({tag, " result"}, 64'(result), 64'(v.exp_result));
        req = '0;
      end
      dp_done  = v.exp_start && (c == 1 + v.dly);
      dp_accum = dp_done ? v.accum : $urandom();
      tick();
    end
    dp_done = 1'b0;
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    // rq, op1, op0, od1, od0, dly, accum, stray, drop | id, start, err, lat, result
    vecs[0] = mk(2'b01, 5'b0, OP_ADD, 16'd0, 16'd5, 2, 32'd5, 0, 0, 0, 1, 0, 4, 32'd5);
    vecs[1] = mk(2'b10, 5'b00110, 5'b0, 16'd0, 16'd0, 0, 32'd0, 0, 0, 1, 0, 1, 1, 32'd5);
    vecs[2] = mk(2'b01, 5'b0, OP_MUL, 16'd0, 16'd7, 0, 32'hAAAA, 0, 0, 0, 1, 1, 17, 32'd5);
    vecs[3] = mk(2'b11, OP_CLR, OP_SUB, 16'h8000, 16'd3, 15, 32'hDEADBEEF, 0, 0,
                 1, 1, 0, 17, 32'hDEADBEEF);
    vecs[4] = mk(2'b01, 5'b0, OP_ADD, 16'd0, 16'hFFFD, 1, 32'h12345678, 1, 1,
                 0, 1, 0, 3, 32'h12345678);
    vecs[5] = mk(2'b11, OP_CTR, OP_ADD, 16'd1, 16'd1, 1, 32'd0, 0, 0, 1, 0, 1, 1, 32'h12345678);
    vecs[6] = mk(2'b01, 5'b0, 5'b0, 16'd0, 16'd0, 1, 32'd0, 0, 0, 0, 0, 1, 1, 32'h12345678);
    vecs[7] = mk(2'b11, OP_ADD, OP_ADD, 16'd2, 16'd2, 16, 32'h55, 0, 0, 1, 1, 1, 17, 32'h12345678);

    reset = 1'b1; req = '0; req_op = '0; req_operand = '0; dp_done = 1'b0; dp_accum = '0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Fairness: both requesters held, each adding 1 through a tiny datapath
    begin
      logic [31:0] acc;
      int k;
      bit pend;
      acc = 0; k = 0; pend = 1'b0;
      req = 2'b11; req_op = {OP_ADD, OP_ADD}; req_operand = {16'd1, 16'd1};
      for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
        if (ack != '0) begin
          chk($sformatf("fair%0d grant_id", k), 64'(grant_id), 64'(k % 2));
          chk($sformatf("fair%0d ack", k), 64'(ack), 64'(2'b01 << (k % 2)));
          chk($sformatf("fair%0d result", k), 64'(result), 64'(k + 1));
          chk($sformatf("fair%0d err", k), 64'(err), 0);
          k++;
          if (k == 4) req = '0;
        end
        dp_done = 1'b0;
        if (pend) begin
          acc = acc + 32'(signed'(dp_operand));
          dp_done = 1'b1; dp_accum = acc; pend = 1'b0;
        end
        if (dp_start) pend = 1'b1;
        tick();
      end
      dp_done = 1'b0;
      chk("fair completions", 64'(k), 4);
    end

    // Reset during WAIT_DONE with the pointer at requester 1
    run_txn(mk(2'b01, 5'b0, OP_ADD, 16'd0, 16'd9, 1, 32'd9, 0, 0, 0, 1, 0, 3, 32'd9), "pre_rst");
    req = 2'b10; req_op = {OP_ADD, 5'b0}; req_operand = {16'd4, 16'd0};
    tick();
    chk("midrst dp_start", 64'(dp_start), 1);
    chk("midrst grant_id", 64'(grant_id), 1);
    req = '0;
    tick();
    tick();
    chk("midrst busy", 64'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      dp_done = (i == 0);
      dp_accum = 32'hBAD;
      tick();
      chk("post-reset ack", 64'(ack), 0);
    end
    dp_done = 1'b0;
    ptr_m = 0; result_m = '0;
    v = mk(2'b11, OP_ADD, OP_ADD, 16'd1, 16'd1, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    predict(v);
    run_txn(v, "post_rst");

    // Randomized transactions against the reference model
    for (int it = 0; it < 200; it++) begin
      v.req = 2'($urandom_range(1, 3));
      for (int r = 0; r < NREQ; r++) begin
        logic [4:0] op;
        if ($urandom_range(0, 3) != 0) op = 5'(1 << $urandom_range(0, 3));
        else op = 5'($urandom());
        v.ops[r*5 +: 5] = op;
        v.opnds[r*16 +: 16] = 16'($urandom());
      end
      v.dly = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 5))
                                          : int'($urandom_range(0, TIMEOUT + 1));
      v.accum = $urandom();
      v.stray = 1'($urandom_range(0, 1));
      v.drop  = 1'($urandom_range(0, 1));
      predict(v);
      run_txn(v, $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exceeded, got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
